sw_lpf_coeff_ctrl: RTL and testbench

Coefficient configuration controller for the 8-sample Shannon-Whittaker lowpass filter. Host writes land in a shadow bank, and a commit copies them atomically into the active bank on a system sync strobe. The controller also drives the per-chain coefficient upshift (3 for the 1/4 chain, 4 for the 2/3 chain). After reset and after every coefficient swap, it masks the filter output valid for the pipeline flush length. It sits between the register interface and the filter's coefficient inputs.

---
 rtl/sw_lpf_coeff_ctrl.sv | 104 ++++++++++
 tb/tb_sw_lpf_coeff_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_lpf_coeff_ctrl.sv
// Coefficient shadow/active bank controller for the 8-tap SW lowpass filter.
// Host writes land in the shadow bank; a commit swaps it into the active bank at sync, then the output is blanked for the flush.
module sw_lpf_coeff_ctrl #(
  parameter int    COEFFBITS    = 18,
  parameter int    UPSHIFT_14   = 3,
  parameter int    UPSHIFT_23   = 4,
  parameter int    FLUSH_CYCLES = 14,
  parameter string REQUIRE_SYNC = "TRUE"
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_i,
  input  logic [2:0]                waddr_i,
  input  logic [COEFFBITS-1:0]      wdata_i,
  input  logic                      commit_i,
  input  logic                      sync_i,
  output logic [7:0][COEFFBITS-1:0] coeff_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_e;

  localparam bit         SYNC_REQ   = (REQUIRE_SYNC == "TRUE");
  localparam logic [7:0] CHAIN14    = 8'b1001_1001;  // taps 0,3,4,7 belong to the 1/4 chain
  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);

  function automatic logic [COEFFBITS-1:0] dflt(input int i);
    int d;
    case (i)
      0:       d = -23;
      1:       d = 105;
      2:       d = -263;
      3:       d = 526;
      4:       d = -949;
      5:       d = 1672;
      6:       d = -3216;
      default: d = 10342;
    endcase
    return COEFFBITS'(d);
  endfunction

  function automatic logic [COEFFBITS-1:0] upshift(input logic [COEFFBITS-1:0] v, input int i);
    return CHAIN14[i] ? (v << UPSHIFT_14) : (v << UPSHIFT_23);
  endfunction

  state_e                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [7:0][COEFFBITS-1:0]   shadow_q;
  logic [7:0][COEFFBITS-1:0]   active_q;   // holds already-upshifted values
  logic                        fit14, fit23, wr_ok, swap;

  // The bits shifted out plus the new sign bit must all agree, otherwise the shift loses sign.
  assign fit14 = (wdata_i[COEFFBITS-1 -: UPSHIFT_14+1] == '0) ||
                 (wdata_i[COEFFBITS-1 -: UPSHIFT_14+1] == '1);
  assign fit23 = (wdata_i[COEFFBITS-1 -: UPSHIFT_23+1] == '0) ||
                 (wdata_i[COEFFBITS-1 -: UPSHIFT_23+1] == '1);
  assign wr_ok = wr_i && (CHAIN14[waddr_i] ? fit14 : fit23) && (state_q != ARMED);
  assign err_d = (wr_i && !wr_ok) || (commit_i && (state_q != IDLE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    case (state_q)
      IDLE:  if (commit_i) state_d = ARMED;
      ARMED: if (sync_i || !SYNC_REQ) begin
        swap    = 1'b1;
        cnt_d   = FLUSH_INIT;
        state_d = FLUSH;
      end
      FLUSH: if (cnt_q == 8'd0) state_d = IDLE;
             else               cnt_d   = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FLUSH;
      cnt_q   <= FLUSH_INIT;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= dflt(i);
        active_q[i] <= upshift(dflt(i), i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (wr_ok) shadow_q[waddr_i] <= wdata_i;
      if (swap)
        for (int i = 0; i < 8; i++) active_q[i] <= upshift(shadow_q[i], i);
    end
  end

  assign coeff_o = active_q;
  assign valid_o = (state_q != FLUSH);
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_sw_lpf_coeff_ctrl.sv
// Scoreboard bench: stimulus pushes (cycle, signal, value) expectations; a negedge monitor pops and checks them.
module tb_sw_lpf_coeff_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, wr, commit, sync;
  logic [2:0]       waddr;
  logic [17:0]      wdata;
  logic [7:0][17:0] coeff;
  logic             valid, busy, err;

  logic             ns_wr, ns_commit, ns_sync;
  logic [2:0]       ns_waddr;
  logic [17:0]      ns_wdata;
  logic [7:0][17:0] ns_coeff;
  logic             ns_valid, ns_busy, ns_err;

  sw_lpf_coeff_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(wr), .waddr_i(waddr), .wdata_i(wdata),
    .commit_i(commit), .sync_i(sync), .coeff_o(coeff), .valid_o(valid),
    .busy_o(busy), .err_o(err)
  );

  sw_lpf_coeff_ctrl #(.REQUIRE_SYNC("FALSE")) dut_ns (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(ns_wr), .waddr_i(ns_waddr), .wdata_i(ns_wdata),
    .commit_i(ns_commit), .sync_i(ns_sync), .coeff_o(ns_coeff), .valid_o(ns_valid),
    .busy_o(ns_busy), .err_o(ns_err)
  );

  // Shifted reset defaults, worked out by hand.
  int DEF [8] = '{-184, 1680, -4208, 4208, -7592, 26752, -51456, 82736};

  localparam int K_COEFF = 0, K_VALID = 1, K_BUSY = 2, K_ERR = 3;
  localparam int K_NCOEFF = 4, K_NVALID = 5, K_NBUSY = 6, K_NERR = 7;

  typedef struct {
    string tag;
    int    at;
    int    kind;
    int    idx;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
  endtask

  function automatic int sample(input int kind, input int idx);
    case (kind)
      K_COEFF:  return int'($signed(coeff[idx]));
      K_VALID:  return int'(valid);
      K_BUSY:   return int'(busy);
      K_ERR:    return int'(err);
      K_NCOEFF: return int'($signed(ns_coeff[idx]));
      K_NVALID: return int'(ns_valid);
      K_NBUSY:  return int'(ns_busy);
      default:  return int'(ns_err);
    endcase
  endfunction

  task automatic push(input string tag, input int at, input int kind, input int idx, input int val);
    exp_t e;
    e.tag = tag; e.at = at; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, sample(sb[i].kind, sb[i].idx), sb[i].val);
        sb.delete(i);
      end
  end

  // One cycle of stimulus; returns just after the edge that sampled it, so cyc names that edge.
  task automatic drive(input bit ns, input bit w, input int a, input int d, input bit c, input bit s);
    if (ns) begin
      ns_wr = w; ns_waddr = 3'(a); ns_wdata = 18'(d); ns_commit = c;
    end else begin
      wr = w; waddr = 3'(a); wdata = 18'(d); commit = c; sync = s;
    end
    @(posedge clk); #1;
    wr = 0; commit = 0; sync = 0; ns_wr = 0; ns_commit = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int k, c, s, r;

  initial begin
    rst_n = 0; wr = 0; commit = 0; sync = 0; waddr = '0; wdata = '0;
    ns_wr = 0; ns_commit = 0; ns_sync = 0; ns_waddr = '0; ns_wdata = '0;

    // Reset state
    idle(3);
    for (int i = 0; i < 8; i++) push("rst_coeff", cyc, K_COEFF, i, DEF[i]);
    push("rst_valid", cyc, K_VALID, 0, 0);
    push("rst_busy",  cyc, K_BUSY,  0, 1);
    push("rst_err",   cyc, K_ERR,   0, 0);
    rst_n = 1;
    k = cyc + 1;
    push("rel_valid_lo", k + 12, K_VALID, 0, 0);
    push("rel_valid_hi", k + 13, K_VALID, 0, 1);
    push("rel_busy_hi",  k + 12, K_BUSY,  0, 1);
    push("rel_busy_lo",  k + 13, K_BUSY,  0, 0);
    idle(15);

    // Write idx3=1000, commit, sync 5 cycles after the commit
    drive(0, 1, 3, 1000, 0, 0);
    push("wr_ok_err", cyc, K_ERR, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    c = cyc;
    push("armed_busy",  c, K_BUSY,  0, 1);
    push("armed_valid", c, K_VALID, 0, 1);
    idle(4);
    push("pre_swap_c3", cyc, K_COEFF, 3, 4208);
    drive(0, 0, 0, 0, 0, 1);
    s = cyc;
    push("swap_c3",     s,      K_COEFF, 3, 8000);
    push("swap_c7",     s,      K_COEFF, 7, 82736);
    push("swap_c1",     s,      K_COEFF, 1, 1680);
    push("flush_v_lo0", s,      K_VALID, 0, 0);
    push("flush_v_lo1", s + 13, K_VALID, 0, 0);
    push("flush_v_hi",  s + 14, K_VALID, 0, 1);
    push("flush_b_lo",  s + 14, K_BUSY,  0, 0);
    idle(16);

    // Out-of-range write to a 2/3-chain tap
    drive(0, 1, 1, 'h1F000, 0, 0);
    push("range_err_hi", cyc,     K_ERR, 0, 1);
    push("range_err_lo", cyc + 1, K_ERR, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    push("range_c1", cyc, K_COEFF, 1, 1680);
    push("range_c3", cyc, K_COEFF, 3, 8000);
    idle(16);

    // Write and second commit while ARMED are both rejected
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 50, 0, 0);
    push("armed_wr_err",  cyc,     K_ERR, 0, 1);
    push("armed_err_gap", cyc + 1, K_ERR, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 1, 0);
    push("armed_cm_err", cyc,     K_ERR, 0, 1);
    push("armed_err_lo", cyc + 1, K_ERR, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    push("frozen_c0", cyc, K_COEFF, 0, -184);
    push("frozen_c3", cyc, K_COEFF, 3, 8000);
    idle(2);
    drive(0, 1, 4, -2000, 0, 0);
    push("flush_wr_err", cyc, K_ERR,   0, 0);
    push("flush_wr_c4",  cyc, K_COEFF, 4, -7592);
    idle(14);

    // Swap the FLUSH-time write in, then reset mid-FLUSH
    drive(0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    push("swap2_c4", cyc, K_COEFF, 4, -16000);
    idle(4);
    rst_n = 0;
    r = cyc + 1;
    push("midrst_c4",    r, K_COEFF, 4, -7592);
    push("midrst_c3",    r, K_COEFF, 3, 4208);
    push("midrst_valid", r, K_VALID, 0, 0);
    push("midrst_busy",  r, K_BUSY,  0, 1);
    idle(3);
    rst_n = 1;
    k = cyc + 1;
    push("rel2_valid_lo", k + 12, K_VALID, 0, 0);
    push("rel2_valid_hi", k + 13, K_VALID, 0, 1);
    idle(15);

    // No-sync instance: commit at edge c, coefficients change one edge later
    drive(1, 1, 7, 5000, 0, 0);
    push("ns_wr_err", cyc, K_NERR, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    c = cyc;
    push("ns_c7_old",  c,     K_NCOEFF, 7, 82736);
    push("ns_busy",    c,     K_NBUSY,  0, 1);
    push("ns_v_armed", c,     K_NVALID, 0, 1);
    push("ns_c7_new",  c + 1, K_NCOEFF, 7, 40000);
    push("ns_v_flush", c + 1, K_NVALID, 0, 0);
    idle(4);

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
